// File: rtl/adc_snap_pkg.sv
// Shared definitions for the ADC snapshot capture controller.
package adc_snap_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int ST_DONE = 31;
  localparam int ST_BUSY = 30;
  localparam int ST_OVR  = 29;

  localparam int CT_EN   = 0;
  localparam int CT_TSRC = 1;
  localparam int CT_WSRC = 2;

endpackage

// File: rtl/adc_snap_capture_ctrl_addr_ctr.sv
// Saturating snapshot word counter (ADDR_W+1 bits) with terminal flag at the last address.
module snap_addr_ctr
  import adc_snap_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W:0]   o_cnt,
  output logic [ADDR_W:0]   o_cnt_nxt,
  output logic              o_term
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W:0] w_cnt_nxt;

  // The MSB marks a full buffer; once set the count never moves again.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (i_inc && !r_cnt[ADDR_W])
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_term    = (r_cnt == LAST);

endmodule

// File: rtl/adc_snap_capture_ctrl.sv
// ADC snapshot capture controller: arm, trigger, write qualified samples, report status.
// Optional sticky overrange flag in status[29] when ADC_SNAP_OVR_FLAG_EN is defined.
//
//   state     | meaning
//   S_IDLE    | after reset, nothing captured
//   S_ARMED   | waiting for trigger (trigger-cycle sample is written)
//   S_CAPTURE | writing qualified samples
//   S_DONE    | buffer full, held until next arm
module adc_snap_capture_ctrl
  import adc_snap_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  input  logic              ext_trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              adc_ovr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_ctrl0_q;
  logic            w_arm;
  logic            w_trig;
  logic            w_qual;
  logic            w_wr;
  logic            w_ovr_nxt;
  logic            w_term;
  logic [ADDR_W:0] w_cnt;
  logic [ADDR_W:0] w_cnt_nxt;
  logic [31:0]     w_status;

  assign w_arm  = ctrl[CT_EN] & ~r_ctrl0_q;
  assign w_trig = ctrl[CT_TSRC] | ext_trig;
  assign w_qual = ctrl[CT_WSRC] | din_valid;
  assign w_wr   = ~w_arm & w_qual &
                  (((r_state == S_ARMED) & w_trig) | (r_state == S_CAPTURE));

  snap_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .i_clk     (user_clk),
    .i_rst     (user_rst),
    .i_clr     (w_arm),
    .i_inc     (w_wr),
    .o_cnt     (w_cnt),
    .o_cnt_nxt (w_cnt_nxt),
    .o_term    (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_arm)
      w_state_nxt = S_ARMED;
    else begin
      if (r_state == S_ARMED && w_trig)
        w_state_nxt = S_CAPTURE;
      if (w_wr && w_term)
        w_state_nxt = S_DONE;
    end
  end

`ifdef ADC_SNAP_OVR_FLAG_EN
  logic r_ovr;
  logic w_unused;

  assign w_ovr_nxt = w_arm ? 1'b0 : (r_ovr | (w_wr & adc_ovr));
  assign w_unused  = ^ctrl[31:3];

  always_ff @(posedge user_clk) begin
    if (user_rst)
      r_ovr <= 1'b0;
    else
      r_ovr <= w_ovr_nxt;
  end
`else
  logic w_unused;

  assign w_ovr_nxt = 1'b0;
  assign w_unused  = ^{ctrl[31:3], adc_ovr};
`endif

  // Status is built from next-state values so done lands with the final write pulse.
  always_comb begin
    w_status           = '0;
    w_status[ADDR_W:0] = w_cnt_nxt;
    w_status[ST_DONE]  = (w_state_nxt == S_DONE);
    w_status[ST_BUSY]  = (w_state_nxt == S_ARMED) | (w_state_nxt == S_CAPTURE);
    w_status[ST_OVR]   = w_ovr_nxt;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state   <= S_IDLE;
      r_ctrl0_q <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
      status    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctrl0_q <= ctrl[CT_EN];
      bram_we   <= w_wr;
      if (w_wr) begin
        bram_addr <= w_cnt[ADDR_W-1:0];
        bram_data <= din;
      end
      status    <= w_status;
    end
  end

endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// Scoreboard bench for adc_snap_capture_ctrl with ADDR_W=4 and a behavioural snapshot model.
module tb_adc_snap_capture_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_FULL = 3;

`ifdef ADC_SNAP_OVR_FLAG_EN
  localparam logic [31:0] FINAL_T1 = 32'hA000_0010;
`else
  localparam logic [31:0] FINAL_T1 = 32'h8000_0010;
`endif

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [31:0] status;
  } exp_t;

  logic              clk;
  logic              user_rst;
  logic [31:0]       ctrl;
  logic              ext_trig;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              adc_ovr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;

  int n_total = 0;
  int n_pass  = 0;
  exp_t expq[$];

  bit m_prev_en = 0;
  int m_phase   = PH_IDLE;
  int m_written = 0;
  bit m_ovr     = 0;

  adc_snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk  (clk),
    .user_rst  (user_rst),
    .ctrl      (ctrl),
    .ext_trig  (ext_trig),
    .din       (din),
    .din_valid (din_valid),
    .adc_ovr   (adc_ovr),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .bram_we   (bram_we),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the snapshot is a list of written samples; done means the list is full.
  always @(posedge clk) begin
    exp_t e;
    bit   arm;
    e.we = 0; e.addr = 0; e.data = 0;
    if (user_rst) begin
      m_prev_en = 0; m_phase = PH_IDLE; m_written = 0; m_ovr = 0;
    end else begin
      arm = ctrl[0] && !m_prev_en;
      m_prev_en = ctrl[0];
      if (arm) begin
        m_phase = PH_WAIT; m_written = 0; m_ovr = 0;
      end else if ((m_phase == PH_WAIT && (ctrl[1] || ext_trig)) || m_phase == PH_RUN) begin
        m_phase = PH_RUN;
        if (ctrl[2] || din_valid) begin
          e.we   = 1;
          e.addr = 64'(m_written);
          e.data = din;
          m_written++;
`ifdef ADC_SNAP_OVR_FLAG_EN
          if (adc_ovr) m_ovr = 1;
`endif
          if (m_written == DEPTH) m_phase = PH_FULL;
        end
      end
    end
    e.status = 32'(m_written);
    if (m_phase == PH_FULL) e.status = e.status + 32'h8000_0000;
    if (m_phase == PH_WAIT || m_phase == PH_RUN) e.status = e.status + 32'h4000_0000;
    if (m_ovr) e.status = e.status + 32'h2000_0000;
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("status", 64'(status), 64'(e.status));
      chk("bram_we", 64'(bram_we), 64'(e.we));
      if (e.we) begin
        chk("bram_addr", 64'(bram_addr), e.addr);
        chk("bram_data", bram_data, e.data);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    user_rst = 1; ctrl = 0; ext_trig = 0; din = 0; din_valid = 0; adc_ovr = 0;
    cyc(3);
    chk("reset_status", 64'(status), 64'h0);
    chk("reset_we", 64'(bram_we), 64'h0);
    chk("reset_addr", 64'(bram_addr), 64'h0);
    user_rst = 0;
    cyc(2);

    // Immediate trigger, write every cycle, overrange on sample 3.
    ctrl = 32'h7;
    cyc();
    chk("t1_armed", 64'(status), 64'h4000_0000);
    for (int k = 0; k < 20; k++) begin
      din = 64'(k); adc_ovr = (k == 3);
      cyc();
    end
    adc_ovr = 0;
    chk("t1_final", 64'(status), 64'(FINAL_T1));
    chk("t1_no_write", 64'(bram_we), 64'h0);
    ctrl = 0;
    cyc();

    // External trigger with din_valid high.
    ctrl = 32'h1; din_valid = 1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      din = {$urandom, $urandom};
      cyc();
      chk("t2_waiting", 64'(status), 64'h4000_0000);
      chk("t2_no_write", 64'(bram_we), 64'h0);
    end
    ext_trig = 1; din = 64'h1234;
    cyc();
    chk("t2_first_we", 64'(bram_we), 64'h1);
    chk("t2_first_addr", 64'(bram_addr), 64'h0);
    ext_trig = 0;
    for (int k = 0; k < 20; k++) begin
      din = {$urandom, $urandom};
      cyc();
    end
    ctrl = 0;
    cyc();

    // Immediate trigger, din_valid toggling.
    ctrl = 32'h3;
    for (int k = 0; k < 40; k++) begin
      din_valid = k[0]; din = {$urandom, $urandom};
      cyc();
    end
    chk("t3_done", 64'(status), 64'h8000_0010);
    ctrl = 0; din_valid = 0;
    cyc();

    // Re-arm mid-capture.
    ctrl = 32'h7;
    cyc(6);
    ctrl = 32'h6;
    cyc();
    ctrl = 32'h7;
    cyc();
    chk("t4_rearm", 64'(status), 64'h4000_0000);
    din = 64'hABCD;
    cyc();
    chk("t4_we", 64'(bram_we), 64'h1);
    chk("t4_addr0", 64'(bram_addr), 64'h0);
    cyc(20);
    ctrl = 0;
    cyc();

    // Reset pulse during capture.
    ctrl = 32'h7;
    cyc(5);
    user_rst = 1; ctrl = 0;
    cyc();
    user_rst = 0;
    chk("t5_status", 64'(status), 64'h0);
    chk("t5_we", 64'(bram_we), 64'h0);
    cyc(5);
    chk("t5_idle", 64'(status), 64'h0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) ctrl[0] = ~ctrl[0];
      if ($urandom_range(0, 9) == 0) ctrl[2:1] = 2'($urandom);
      ctrl[31:3] = 29'($urandom);
      ext_trig  = ($urandom_range(0, 7) == 0);
      din_valid = 1'($urandom);
      adc_ovr   = ($urandom_range(0, 9) == 0);
      din       = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) user_rst = 1; else user_rst = 0;
      cyc();
    end
    user_rst = 0;
    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
